// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - handshaked sequential ALU with iterative shifts
// Optional iterative shift-add multiplier for op 101 when ALU_MUL_EN is defined.
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             zero,
  output logic             ex
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SLL = 3'b011;
  localparam logic [2:0] OP_SRL = 3'b100;
`ifdef ALU_MUL_EN
  localparam logic [2:0] OP_MUL = 3'b101;
`endif
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opr_q, opr_d;
  logic [2:0]       op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] z_q, z_d;
  logic             zero_q, zero_d;
  logic             ex_q, ex_d;
`ifdef ALU_MUL_EN
  logic [WIDTH-1:0] mlt_q, mlt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] acc_nxt;
`endif

  logic [WIDTH-1:0] sum, diff, res, nxt;
  logic [SHW-1:0]   shamt;
  logic             res_ex;

  assign sum   = a + b;
  assign diff  = a - b;
  assign shamt = b[SHW-1:0];

  assign in_ready  = (state_q == IDLE) && rst_n;
  assign out_valid = (state_q == DONE);
  assign z         = z_q;
  assign zero      = zero_q;
  assign ex        = ex_q;

  always_comb begin
    state_d = state_q;
    opr_d   = opr_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    z_d     = z_q;
    zero_d  = zero_q;
    ex_d    = ex_q;
    res     = '0;
    res_ex  = 1'b0;
    nxt     = '0;
`ifdef ALU_MUL_EN
    mlt_d   = mlt_q;
    acc_d   = acc_q;
    acc_nxt = '0;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          op_d    = op;
          opr_d   = a;
          state_d = DONE;
          case (op)
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            OP_ADD: begin
              res    = sum;
              res_ex = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
              res    = diff;
              res_ex = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLT: res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SLL, OP_SRL: begin
              res = a;
              if (shamt != '0) begin
                state_d = EXEC;
                cnt_d   = CW'(shamt);
              end
            end
`ifdef ALU_MUL_EN
            OP_MUL: begin
              state_d = EXEC;
              cnt_d   = CW'(WIDTH);
              mlt_d   = b;
              acc_d   = '0;
            end
`endif
            default: begin
              res    = '0;
              res_ex = 1'b1;
            end
          endcase
          if (state_d == DONE) begin
            z_d    = res;
            zero_d = (res == '0);
            ex_d   = res_ex;
          end
        end
      end
      EXEC: begin
        cnt_d = cnt_q - CW'(1);
        nxt   = (op_q == OP_SRL) ? (opr_q >> 1) : (opr_q << 1);
        opr_d = nxt;
        res   = nxt;
`ifdef ALU_MUL_EN
        // Multiplicand shifts left while the multiplier is consumed LSB first.
        if (op_q == OP_MUL) begin
          acc_nxt = acc_q + (mlt_q[0] ? opr_q : '0);
          acc_d   = acc_nxt;
          mlt_d   = mlt_q >> 1;
          res     = acc_nxt;
        end
`endif
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          z_d     = res;
          zero_d  = (res == '0);
          ex_d    = 1'b0;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      opr_q   <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
      z_q     <= '0;
      zero_q  <= 1'b0;
      ex_q    <= 1'b0;
`ifdef ALU_MUL_EN
      mlt_q   <= '0;
      acc_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      opr_q   <= opr_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      z_q     <= z_d;
      zero_q  <= zero_d;
      ex_q    <= ex_d;
`ifdef ALU_MUL_EN
      mlt_q   <= mlt_d;
      acc_q   <= acc_d;
`endif
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - self-checking bench for seq_alu (WIDTH=32)
module tb_seq_alu;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] z;
  logic        zero;
  logic        ex;

  int checks   = 0;
  int failures = 0;

  localparam longint MAXS = 64'sd2147483647;
  localparam longint MINS = -64'sd2147483648;

  seq_alu #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z         (z),
    .zero      (zero),
    .ex        (ex)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void ref_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                 output logic [31:0] r, output logic e, output int l);
    longint sx, sy, t;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    r = '0;
    e = 1'b0;
    l = 1;
    case (o)
      3'b000: r = x & y;
      3'b001: r = x | y;
      3'b010: begin t = sx + sy; r = x + y; e = (t > MAXS) || (t < MINS); end
      3'b110: begin t = sx - sy; r = x - y; e = (t > MAXS) || (t < MINS); end
      3'b111: r = (sx < sy) ? 32'd1 : 32'd0;
      3'b011: begin r = x << y[4:0]; l = 1 + int'(y[4:0]); end
      3'b100: begin r = x >> y[4:0]; l = 1 + int'(y[4:0]); end
`ifdef ALU_MUL_EN
      3'b101: begin r = x * y; l = 33; end
`else
      3'b101: begin r = '0; e = 1'b1; end
`endif
      default: ;
    endcase
  endfunction

  task automatic run_op(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                        input int hold, input bit poke);
    logic [31:0] ez;
    logic        eex;
    int          elat;
    int          lat;
    ref_op(o, av, bv, ez, eex, elat);
    @(negedge clk);
    check("in_ready_idle", in_ready, 1);
    in_valid  = 1'b1;
    a         = av;
    b         = bv;
    op        = o;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    a        = $urandom;
    b        = $urandom;
    op       = 3'($urandom);
    check("busy_after_accept", in_ready, 0);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, elat);
    check("z", z, ez);
    check("zero", zero, (ez == 32'd0));
    check("ex", ex, eex);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_z", z, ez);
      check("hold_ex", ex, eex);
    end
    out_ready = 1'b1;
    if (poke) begin
      in_valid = 1'b1;
      op       = 3'b000;
    end
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("drop_valid", out_valid, 0);
    check("back_idle", in_ready, 1);
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    op        = 3'b010;
    a         = 32'd5;
    b         = 32'd6;
    out_ready = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_z", z, 0);
      check("rst_zero", zero, 0);
      check("rst_ex", ex, 0);
    end
    rst_n    = 1'b1;
    in_valid = 1'b0;

    run_op(3'b010, 32'h7FFFFFFF, 32'h00000001, 0, 0);
    run_op(3'b110, 32'h00001234, 32'h00001234, 0, 0);
    run_op(3'b111, 32'hFFFFFFFF, 32'h00000001, 0, 1);
    run_op(3'b011, 32'h00000001, 32'd31, 5, 0);
    run_op(3'b011, 32'hDEADBEEF, 32'h00000020, 1, 1);
    run_op(3'b100, 32'h80000000, 32'd31, 0, 0);
    run_op(3'b110, 32'h80000000, 32'h00000001, 0, 0);
    run_op(3'b101, 32'd3, 32'd5, 1, 0);

    // Reset during the second EXEC cycle of an SRL must discard the operation.
    @(negedge clk);
    check("t5_ready", in_ready, 1);
    in_valid = 1'b1;
    a        = 32'h80000000;
    b        = 32'd4;
    op       = 3'b100;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("t5_rst_valid", out_valid, 0);
    check("t5_rst_ready", in_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_ready_after", in_ready, 1);
    check("t5_z_cleared", z, 0);
    repeat (6) begin
      @(negedge clk);
      check("t5_no_valid", out_valid, 0);
    end

    for (int n = 0; n < 60; n++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) ra = rb;
      run_op(ro, ra, rb, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
